// File: rtl/pipe_arbiter_pkg.sv
// Shared constants and types for the two-requester pipe arbiter.
// Defines the in-flight tag that travels alongside the shared pipe.
package pipe_arbiter_pkg;

   localparam int N_DEF   = 10;
   localparam int LAT_DEF = 3;
   localparam int TAG_W   = 2;

   typedef enum logic {
      OWNER_R0 = 1'b0,
      OWNER_R1 = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_t;

endpackage

// File: rtl/pipe_tag_delay.sv
// LAT-deep shift register of {valid, owner} tags, kept in step with the pipe.
// A synchronous clear drops every in-flight tag, so pending results are never returned.
module pipe_tag_delay
   import pipe_arbiter_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t sr [LAT];

   // NOTE: this storage is reset on purpose; a stale valid tag would return a bogus result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) sr[i] <= '0;
      end else begin
         sr[0] <= tag_in;
         for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
      end
   end

   assign tag_out = sr[LAT-1];

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipe between two requesters.
// Owner tags ride alongside the pipe, and each result is routed back to its owner.
module pipe_arbiter
   import pipe_arbiter_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int LAT = LAT_DEF,
   localparam int IW = $clog2(LAT + 2)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           r0_valid,
   input  logic [4*N-1:0] r0_ops,
   output logic           r0_ready,
   output logic           r0_res_valid,
   output logic [N-1:0]   r0_res,
   input  logic           r1_valid,
   input  logic [4*N-1:0] r1_ops,
   output logic           r1_ready,
   output logic           r1_res_valid,
   output logic [N-1:0]   r1_res,
   output logic [N-1:0]   p_a,
   output logic [N-1:0]   p_b,
   output logic [N-1:0]   p_c,
   output logic [N-1:0]   p_d,
   input  logic [N-1:0]   p_f,
   output logic [IW-1:0]  inflight
);

   owner_t         pref;
   logic           xfer;
   logic [4*N-1:0] sel_ops;
   tag_t           tag_in;
   tag_t           tag_out;
   logic           ret;

   // NOTE: every output gets a default first so this block can never infer a latch.
   always_comb begin
      r0_ready = 1'b0;
      r1_ready = 1'b0;
      if (en && !rst) begin
         if (r0_valid && (!r1_valid || pref == OWNER_R0)) r0_ready = 1'b1;
         else if (r1_valid)                               r1_ready = 1'b1;
      end
   end

   assign xfer    = (r0_valid & r0_ready) | (r1_valid & r1_ready);
   assign sel_ops = r1_ready ? r1_ops : r0_ops;
   assign tag_in  = '{valid: xfer, owner: (r1_ready ? OWNER_R1 : OWNER_R0)};
   assign ret     = tag_out.valid;

   pipe_tag_delay #(.LAT(LAT)) u_tag_delay (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pref         <= OWNER_R0;
         p_a          <= '0;
         p_b          <= '0;
         p_c          <= '0;
         p_d          <= '0;
         r0_res       <= '0;
         r1_res       <= '0;
         r0_res_valid <= 1'b0;
         r1_res_valid <= 1'b0;
         inflight     <= '0;
      end else begin
         // Idle cycles feed zeros so the pipe never sees stale operands.
         if (xfer) begin
            p_a  <= sel_ops[4*N-1 -: N];
            p_b  <= sel_ops[3*N-1 -: N];
            p_c  <= sel_ops[2*N-1 -: N];
            p_d  <= sel_ops[N-1:0];
            pref <= r1_ready ? OWNER_R0 : OWNER_R1;
         end else begin
            p_a <= '0;
            p_b <= '0;
            p_c <= '0;
            p_d <= '0;
         end

         r0_res_valid <= ret && (tag_out.owner == OWNER_R0);
         r1_res_valid <= ret && (tag_out.owner == OWNER_R1);
         if (ret && tag_out.owner == OWNER_R0) r0_res <= p_f;
         if (ret && tag_out.owner == OWNER_R1) r1_res <= p_f;

         case ({xfer, ret})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule
